// File: rtl/controle_multiciclo_if.sv
// Control bus between the multi-cycle controller (master) and the datapath (slave).
interface controle_multiciclo_if #(
  parameter int ULAOP_W = 3,
  parameter int CNT_W   = 8
);
  logic               run;
  logic [3:0]         inst_code;
  logic               zero;
  logic               dmem_ready;
  logic               ir_write;
  logic               pc_write;
  logic [1:0]         pc_src;
  logic [ULAOP_W-1:0] ula_op;
  logic               ula_src;
  logic               atr;
  logic               beq;
  logic               mem_read;
  logic               mem_write;
  logic               mem_to_reg;
  logic               reg_write;
  logic               halted;
  logic               err;
  logic [CNT_W-1:0]   instr_count;
  logic [2:0]         state;

  modport master (
    input  run, inst_code, zero, dmem_ready,
    output ir_write, pc_write, pc_src, ula_op, ula_src, atr, beq,
           mem_read, mem_write, mem_to_reg, reg_write, halted, err,
           instr_count, state
  );

  modport slave (
    output run, inst_code, zero, dmem_ready,
    input  ir_write, pc_write, pc_src, ula_op, ula_src, atr, beq,
           mem_read, mem_write, mem_to_reg, reg_write, halted, err,
           instr_count, state
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB plus HALT and ERR.
// Opcode map: 00xx jump, 01xx beq, 1000 add, 1001 lw, 1010 sw, 1011 slt,
//             1100 halt, 1101 addi, 1110 atr, 1111 sll.
// lw/sw go DECODE -> MEM directly; the address add (ula_op 000, ula_src 0)
// is the all-zero ULA setting, so MEM needs no extra drive for it.
// Optional: CTRL_MEM_TIMEOUT_EN enables the MEM wait-state timeout trap (ERR).
module controle_multiciclo #(
  parameter int ULAOP_W      = 3,
  parameter int CNT_W        = 8,
  parameter int MEM_WAIT_MAX = 15
) (
  input logic               clk,
  input logic               rst_n,
  controle_multiciclo_if.master bus
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [3:0] OP_LW   = 4'b1001;
  localparam logic [3:0] OP_SW   = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1100;
  localparam logic [3:0] OP_ADDI = 4'b1101;
  localparam logic [3:0] OP_ATR  = 4'b1110;
  localparam logic [3:0] OP_SLL  = 4'b1111;

  logic [2:0]         r_state, w_next;
  logic [3:0]         r_opcode;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_retire;
  logic               w_irw, w_pcw, w_usrc, w_atr, w_beq, w_mr, w_mw, w_m2r, w_rw;
  logic [1:0]         w_pcs;
  logic [ULAOP_W-1:0] w_uop;
  logic               w_wait_lim;

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int WC_W = $clog2(MEM_WAIT_MAX + 1);
  logic [WC_W-1:0] r_wcnt;

  // Count ready-low cycles of the current MEM visit; cleared outside MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_wcnt <= '0;
    else if (r_state != S_MEM) r_wcnt <= '0;
    else if (!bus.dmem_ready)  r_wcnt <= r_wcnt + 1'b1;
  end

  assign w_wait_lim = (r_wcnt == WC_W'(MEM_WAIT_MAX - 1));
`else
  assign w_wait_lim = 1'b0;
`endif

  // State, latched opcode and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_opcode <= 4'd0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= bus.inst_code;
      if (w_retire)            r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Next state and control decode; inst_code is only looked at in DECODE.
  always_comb begin
    w_next = r_state; w_retire = 1'b0;
    w_irw = 1'b0; w_pcw = 1'b0; w_pcs = 2'b00; w_uop = '0;
    w_usrc = 1'b0; w_atr = 1'b0; w_beq = 1'b0;
    w_mr = 1'b0; w_mw = 1'b0; w_m2r = 1'b0; w_rw = 1'b0;
    case (r_state)
      S_FETCH: if (bus.run) begin
        w_irw = 1'b1; w_pcw = 1'b1; w_next = S_DECODE;
      end
      S_DECODE: casez (bus.inst_code)
        4'b00??: begin w_pcw = 1'b1; w_pcs = 2'b01; w_retire = 1'b1; w_next = S_FETCH; end
        OP_HALT: w_next = S_HALT;
        OP_LW, OP_SW: w_next = S_MEM;
        default: w_next = S_EXEC;
      endcase
      S_EXEC: begin
        w_next = S_WB;
        casez (r_opcode)
          4'b01??: begin
            w_uop = ULAOP_W'(3'b100); w_beq = 1'b1; w_pcw = bus.zero;
            w_pcs = 2'b10; w_retire = 1'b1; w_next = S_FETCH;
          end
          OP_SLT:  w_uop = ULAOP_W'(3'b010);
          OP_ADDI: w_usrc = 1'b1;
          OP_ATR:  begin w_uop = ULAOP_W'(3'b001); w_usrc = 1'b1; w_atr = 1'b1; end
          OP_SLL:  begin w_uop = ULAOP_W'(3'b011); w_usrc = 1'b1; end
          OP_LW, OP_SW: w_next = S_MEM;
          default: ;
        endcase
      end
      S_MEM: begin
        w_mr = (r_opcode == OP_LW);
        w_mw = (r_opcode == OP_SW);
        if (bus.dmem_ready) begin
          if (r_opcode == OP_LW) w_next = S_WB;
          else begin w_retire = 1'b1; w_next = S_FETCH; end
        end else if (w_wait_lim) begin
          w_next = S_ERR;
        end
      end
      S_WB: begin
        w_rw = 1'b1; w_m2r = (r_opcode == OP_LW);
        w_retire = 1'b1; w_next = S_FETCH;
      end
      S_HALT, S_ERR: ;
      default: w_next = S_FETCH;
    endcase
  end

  // Outputs forced low while reset is asserted (FETCH alone would raise ir_write).
  assign bus.ir_write    = rst_n & w_irw;
  assign bus.pc_write    = rst_n & w_pcw;
  assign bus.pc_src      = rst_n ? w_pcs : 2'b00;
  assign bus.ula_op      = rst_n ? w_uop : '0;
  assign bus.ula_src     = rst_n & w_usrc;
  assign bus.atr         = rst_n & w_atr;
  assign bus.beq         = rst_n & w_beq;
  assign bus.mem_read    = rst_n & w_mr;
  assign bus.mem_write   = rst_n & w_mw;
  assign bus.mem_to_reg  = rst_n & w_m2r;
  assign bus.reg_write   = rst_n & w_rw;
  assign bus.halted      = rst_n & (r_state == S_HALT);
`ifdef CTRL_MEM_TIMEOUT_EN
  assign bus.err         = rst_n & (r_state == S_ERR);
`else
  assign bus.err         = 1'b0;
`endif
  assign bus.instr_count = r_cnt;
  assign bus.state       = r_state;
endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: per-cycle expected vectors are queued with
// the stimulus that produces them, then drained and compared.
module tb_controle_multiciclo;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  controle_multiciclo_if #(.ULAOP_W(3), .CNT_W(8)) bus();
  controle_multiciclo #(.ULAOP_W(3), .CNT_W(8), .MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed { logic run; logic [3:0] ic; logic zero; logic rdy; } stim_t;
  typedef struct packed {
    logic [2:0] st; logic irw, pcw; logic [1:0] pcs; logic [2:0] uop;
    logic usrc, atr, beq, mr, mw, m2r, rw, halted, err; logic [7:0] cnt;
  } exp_t;
  typedef struct { stim_t s; exp_t e; string tag; } ent_t;

  ent_t sbq[$];
  int n_cmp = 0, n_bad = 0;
  logic [7:0] m_cnt = 8'd0;

  function automatic exp_t observe();
    exp_t g;
    g.st = bus.state; g.irw = bus.ir_write; g.pcw = bus.pc_write; g.pcs = bus.pc_src;
    g.uop = bus.ula_op; g.usrc = bus.ula_src; g.atr = bus.atr; g.beq = bus.beq;
    g.mr = bus.mem_read; g.mw = bus.mem_write; g.m2r = bus.mem_to_reg;
    g.rw = bus.reg_write; g.halted = bus.halted; g.err = bus.err; g.cnt = bus.instr_count;
    return g;
  endfunction

  function automatic exp_t ez(logic [2:0] st);
    exp_t e = '0; e.st = st; e.cnt = m_cnt; return e;
  endfunction

  // Non-decode cycles get random inst_code/zero/ready: they must be ignored.
  function automatic stim_t sr(logic rdy_ctl, logic rdy_val, logic z_ctl, logic z_val);
    stim_t s;
    s.run = 1'b1; s.ic = 4'($urandom);
    s.zero = z_ctl ? z_val : 1'($urandom);
    s.rdy  = rdy_ctl ? rdy_val : 1'($urandom);
    return s;
  endfunction

  task automatic push(stim_t s, exp_t e, string tag);
    ent_t x; x.s = s; x.e = e; x.tag = tag; sbq.push_back(x);
  endtask

  task automatic apply(stim_t s);
    bus.run = s.run; bus.inst_code = s.ic; bus.zero = s.zero; bus.dmem_ready = s.rdy;
    @(negedge clk);
  endtask

  // Queue the full expected cycle trace of one instruction.
  task automatic gen_instr(logic [3:0] op, logic z, int waits, string tag);
    exp_t e; stim_t s;
    e = ez(3'd0); e.irw = 1; e.pcw = 1; push(sr(0, 0, 0, 0), e, {tag, "/F"});
    e = ez(3'd1); s = sr(0, 0, 0, 0); s.ic = op;
    if (op[3:2] == 2'b00) begin e.pcw = 1; e.pcs = 2'b01; end
    push(s, e, {tag, "/D"});
    if (op[3:2] == 2'b00) begin m_cnt++; return; end
    if (op == 4'b1100) return;
    if (op == 4'b1001 || op == 4'b1010) begin
      for (int i = 0; i <= waits; i++) begin
        e = ez(3'd3); e.mr = (op == 4'b1001); e.mw = (op == 4'b1010);
        push(sr(1, i == waits, 0, 0), e, {tag, "/M"});
      end
      if (op == 4'b1010) begin m_cnt++; return; end
      e = ez(3'd4); e.rw = 1; e.m2r = 1; push(sr(0, 0, 0, 0), e, {tag, "/W"});
      m_cnt++; return;
    end
    e = ez(3'd2);
    case (op)
      4'b1011: e.uop = 3'b010;
      4'b1101: e.usrc = 1;
      4'b1110: begin e.uop = 3'b001; e.usrc = 1; e.atr = 1; end
      4'b1111: begin e.uop = 3'b011; e.usrc = 1; end
      default: ;
    endcase
    if (op[3:2] == 2'b01) begin e.uop = 3'b100; e.beq = 1; e.pcw = z; e.pcs = 2'b10; end
    push(sr(0, 0, 1, z), e, {tag, "/E"});
    if (op[3:2] == 2'b01) begin m_cnt++; return; end
    e = ez(3'd4); e.rw = 1; push(sr(0, 0, 0, 0), e, {tag, "/W"});
    m_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #2; rst_n = 1'b1; m_cnt = 8'd0;
  endtask

  task test_reset();
    exp_t g;
    bus.run = 1'b1; bus.inst_code = 4'b1000; bus.zero = 1'b1; bus.dmem_ready = 1'b1;
    #2; g = observe();
    n_cmp++; if (g !== exp_t'(0)) begin n_bad++; $display("FAIL reset_outputs got %h want 0", g); end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task test_alu();
    ent_t x; exp_t g;
    gen_instr(4'b1000, 0, 0, "add"); gen_instr(4'b1011, 0, 0, "slt");
    gen_instr(4'b1101, 0, 0, "addi"); gen_instr(4'b1110, 0, 0, "atr");
    gen_instr(4'b1111, 0, 0, "sll");
    while (sbq.size() > 0) begin
      x = sbq.pop_front(); apply(x.s); g = observe(); n_cmp++;
      if (g !== x.e) begin n_bad++; $display("FAIL %s got %h want %h", x.tag, g, x.e); end
      @(posedge clk); #1;
    end
  endtask

  task test_mem();
    ent_t x; exp_t g;
    gen_instr(4'b1001, 0, 0, "lw0"); gen_instr(4'b1001, 0, 3, "lw3");
    gen_instr(4'b1010, 0, 0, "sw0"); gen_instr(4'b1010, 0, 2, "sw2");
    while (sbq.size() > 0) begin
      x = sbq.pop_front(); apply(x.s); g = observe(); n_cmp++;
      if (g !== x.e) begin n_bad++; $display("FAIL %s got %h want %h", x.tag, g, x.e); end
      @(posedge clk); #1;
    end
  endtask

  task test_branch();
    ent_t x; exp_t g; stim_t s;
    gen_instr(4'b0010, 0, 0, "jump"); gen_instr(4'b0100, 1, 0, "beq_z1");
    gen_instr(4'b0111, 0, 0, "beq_z0");
    s = sr(0, 0, 0, 0); s.run = 0;
    for (int i = 0; i < 3; i++) push(s, ez(3'd0), "idle");
    while (sbq.size() > 0) begin
      x = sbq.pop_front(); apply(x.s); g = observe(); n_cmp++;
      if (g !== x.e) begin n_bad++; $display("FAIL %s got %h want %h", x.tag, g, x.e); end
      @(posedge clk); #1;
    end
  endtask

  task test_back_to_back();
    ent_t x; exp_t g;
    logic [3:0] ops [8];
    ops = '{4'b1000, 4'b1001, 4'b0101, 4'b1010, 4'b0001, 4'b1111, 4'b1110, 4'b1011};
    for (int i = 0; i < 8; i++) gen_instr(ops[i], 1'($urandom), $urandom_range(0, 2), "b2b");
    for (int i = 0; i < 256; i++) gen_instr(4'b0011, 0, 0, "wrap");
    gen_instr(4'b1000, 0, 0, "post_wrap");
    while (sbq.size() > 0) begin
      x = sbq.pop_front(); apply(x.s); g = observe(); n_cmp++;
      if (g !== x.e) begin n_bad++; $display("FAIL %s got %h want %h", x.tag, g, x.e); end
      @(posedge clk); #1;
    end
  endtask

  task test_mid_mem_reset();
    ent_t x; exp_t g; bit hit = 0;
    gen_instr(4'b1001, 0, 6, "lw_rst");
    while (sbq.size() > 0 && !hit) begin
      x = sbq.pop_front(); apply(x.s); g = observe(); n_cmp++;
      if (g !== x.e) begin n_bad++; $display("FAIL %s got %h want %h", x.tag, g, x.e); end
      if (x.e.mr && x.e.st == 3'd3 && sbq.size() < 5) hit = 1;
      else begin @(posedge clk); #1; end
    end
    sbq.delete();
    rst_n = 1'b0; #1; g = observe(); n_cmp++;
    if (g !== exp_t'(0)) begin n_bad++; $display("FAIL async_reset got %h want 0", g); end
    @(posedge clk); #1; rst_n = 1'b1; m_cnt = 8'd0;
    gen_instr(4'b1000, 0, 0, "after_rst");
    while (sbq.size() > 0) begin
      x = sbq.pop_front(); apply(x.s); g = observe(); n_cmp++;
      if (g !== x.e) begin n_bad++; $display("FAIL %s got %h want %h", x.tag, g, x.e); end
      @(posedge clk); #1;
    end
  endtask

`ifdef CTRL_MEM_TIMEOUT_EN
  task test_timeout();
    ent_t x; exp_t g; exp_t e;
    gen_instr(4'b1010, 0, 14, "sw_lim_ready");
    e = ez(3'd0); e.irw = 1; e.pcw = 1; push(sr(0, 0, 0, 0), e, "sw_to/F");
    push(sr(0, 0, 0, 0) | stim_t'({1'b0, 4'b1010, 2'b00}), ez(3'd1), "sw_to/D");
    for (int i = 0; i < 15; i++) begin
      e = ez(3'd3); e.mw = 1; push(sr(1, 0, 0, 0), e, "sw_to/M");
    end
    for (int i = 0; i < 4; i++) begin
      e = ez(3'd6); e.err = 1; push(sr(0, 0, 0, 0), e, "sw_to/ERR");
    end
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      if (x.tag == "sw_to/D") x.s.ic = 4'b1010;
      apply(x.s); g = observe(); n_cmp++;
      if (g !== x.e) begin n_bad++; $display("FAIL %s got %h want %h", x.tag, g, x.e); end
      @(posedge clk); #1;
    end
    do_reset();
  endtask
`endif

  task test_halt();
    ent_t x; exp_t g; exp_t e;
    gen_instr(4'b1000, 0, 0, "pre_halt");
    gen_instr(4'b1100, 0, 0, "halt");
    for (int i = 0; i < 10; i++) begin
      e = ez(3'd5); e.halted = 1; push(sr(0, 0, 0, 0), e, "halt_hold");
    end
    while (sbq.size() > 0) begin
      x = sbq.pop_front(); apply(x.s); g = observe(); n_cmp++;
      if (g !== x.e) begin n_bad++; $display("FAIL %s got %h want %h", x.tag, g, x.e); end
      @(posedge clk); #1;
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_back_to_back();
    test_mid_mem_reset();
`ifdef CTRL_MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
